spi_master: RTL and testbench

Single-clock SPI command master that drives the SPI slave / RAM wrapper's serial pins (MOSI, SS_n) and collects its MISO replies. A host issues one 2-bit command plus 8-bit payload per transaction. The block serialises a 10-bit frame, and for read-data commands captures the 8-bit reply. It sits directly upstream of the SPI wrapper and shares its clock and reset.

---
 rtl/spi_master_if.sv | 29 ++
 rtl/spi_master.sv | 171 +++++++++++++++++
 tb/tb_spi_master.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_if
// Purpose  : Host command bus plus SPI pins for spi_master.
// Revision : 1.0
// ============================================================================
interface spi_master_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       MOSI;
    logic       MISO;
    logic       SS_n;

    modport master (
        input  start, cmd, wdata, MISO,
        output busy, done, rdata, rdata_valid, MOSI, SS_n
    );

    modport slave (
        output start, cmd, wdata, MISO,
        input  busy, done, rdata, rdata_valid, MOSI, SS_n
    );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : Serialises a {cmd,wdata} frame over SPI; captures 8-bit replies.
// Revision : 1.0
// ============================================================================
module spi_master #(
    parameter int LEAD_CYCLES = 1,
    parameter int TURN_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_master_if.master  bus
);

    localparam int c_max_lt  = (LEAD_CYCLES > TURN_CYCLES) ? LEAD_CYCLES : TURN_CYCLES;
    localparam int c_max_dly = (c_max_lt > GAP_CYCLES) ? c_max_lt : GAP_CYCLES;
    localparam int c_dly_w   = $clog2(c_max_dly) + 1;

    localparam logic [c_dly_w-1:0] c_lead_last = c_dly_w'(LEAD_CYCLES - 1);
    localparam logic [c_dly_w-1:0] c_turn_last = c_dly_w'(TURN_CYCLES - 1);
    localparam logic [c_dly_w-1:0] c_gap_last  = c_dly_w'(GAP_CYCLES - 1);
    localparam logic [3:0]         c_shift_last   = 4'd9;
    localparam logic [3:0]         c_capture_last = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_TURN    = 3'd3,
        S_CAPTURE = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t               r_state;
    logic [9:0]           r_frame;
    logic                 r_is_read;
    logic [3:0]           r_bit_cnt;
    logic [c_dly_w-1:0]   r_dly_cnt;
    logic [7:0]           r_shift;
    logic [7:0]           r_rdata;
    logic                 r_mosi;
    logic                 r_ss_n;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_rdata_valid;

    logic                 w_gap_end;
    logic                 w_accept;

    // The final gap cycle counts as ready so a held start gives exactly
    // GAP_CYCLES of SS_n high between frames.
    assign w_gap_end = (r_state == S_GAP) && (r_dly_cnt == c_gap_last);
    assign w_accept  = bus.start && ((r_state == S_IDLE) || w_gap_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_frame       <= '0;
            r_is_read     <= 1'b0;
            r_bit_cnt     <= '0;
            r_dly_cnt     <= '0;
            r_shift       <= '0;
            r_rdata       <= '0;
            r_mosi        <= 1'b0;
            r_ss_n        <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_rdata_valid <= 1'b0;

            if (w_accept) begin
                r_frame   <= {bus.cmd, bus.wdata};
                r_is_read <= (bus.cmd == 2'b11);
                r_state   <= S_LEAD;
                r_ss_n    <= 1'b0;
                r_mosi    <= 1'b0;
                r_busy    <= 1'b1;
                r_dly_cnt <= '0;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                    end

                    S_LEAD: begin
                        if (r_dly_cnt == c_lead_last) begin
                            r_state   <= S_SHIFT;
                            r_bit_cnt <= '0;
                            r_mosi    <= r_frame[9];
                            r_frame   <= {r_frame[8:0], 1'b0};
                        end else begin
                            r_dly_cnt <= r_dly_cnt + 1'b1;
                        end
                    end

                    // r_frame is pre-shifted, so bit 9 is always the next bit out.
                    S_SHIFT: begin
                        if (r_bit_cnt == c_shift_last) begin
                            r_mosi    <= 1'b0;
                            r_dly_cnt <= '0;
                            if (r_is_read) begin
                                r_state <= S_TURN;
                            end else begin
                                r_state <= S_GAP;
                                r_ss_n  <= 1'b1;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_mosi    <= r_frame[9];
                            r_frame   <= {r_frame[8:0], 1'b0};
                        end
                    end

                    S_TURN: begin
                        if (r_dly_cnt == c_turn_last) begin
                            r_state   <= S_CAPTURE;
                            r_bit_cnt <= '0;
                        end else begin
                            r_dly_cnt <= r_dly_cnt + 1'b1;
                        end
                    end

                    S_CAPTURE: begin
                        r_shift <= {r_shift[6:0], bus.MISO};
                        if (r_bit_cnt == c_capture_last) begin
                            r_rdata       <= {r_shift[6:0], bus.MISO};
                            r_rdata_valid <= 1'b1;
                            r_done        <= 1'b1;
                            r_ss_n        <= 1'b1;
                            r_dly_cnt     <= '0;
                            r_state       <= S_GAP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end

                    S_GAP: begin
                        if (w_gap_end) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_dly_cnt <= r_dly_cnt + 1'b1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_ss_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.MOSI        = r_mosi;
    assign bus.SS_n        = r_ss_n;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Randomised self-checking bench for spi_master against a RAM-slave model.
// Revision : 1.0
// ============================================================================
module tb_spi_master;

    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       miso;
    logic       sel;

    int n_checks = 0;
    int n_pass   = 0;

    spi_master_if if0 ();
    spi_master_if if1 ();

    assign if0.start = start;
    assign if0.cmd   = cmd;
    assign if0.wdata = wdata;
    assign if0.MISO  = miso;
    assign if1.start = start;
    assign if1.cmd   = cmd;
    assign if1.wdata = wdata;
    assign if1.MISO  = miso;

    spi_master #(.LEAD_CYCLES(1), .TURN_CYCLES(2), .GAP_CYCLES(1)) u_dut_def (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.master)
    );

    spi_master #(.LEAD_CYCLES(3), .TURN_CYCLES(1), .GAP_CYCLES(1)) u_dut_swp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.master)
    );

    logic       busy, done, rv, mosi, ss_n;
    logic [7:0] rdata;
    assign busy  = sel ? if1.busy        : if0.busy;
    assign done  = sel ? if1.done        : if0.done;
    assign rv    = sel ? if1.rdata_valid : if0.rdata_valid;
    assign mosi  = sel ? if1.MOSI        : if0.MOSI;
    assign ss_n  = sel ? if1.SS_n        : if0.SS_n;
    assign rdata = sel ? if1.rdata       : if0.rdata;

    always #5 clk = ~clk;

    // RAM-slave reference: address/data registers and memory.
    logic [7:0] mem [256];
    logic [7:0] waddr, raddr;
    logic [7:0] exp_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One full transaction; expectations derive from the frame/timing rules.
    task automatic run_txn(input logic [1:0] c, input logic [7:0] d,
                           input logic [7:0] reply, input bit poke);
        int lead, turn, fend, cap0, ss_low, n_done, done_at, n_rv, stray;
        logic [9:0] got_frame;
        logic [7:0] rd_end;
        logic       busy_end;
        lead = sel ? 3 : 1;
        turn = sel ? 1 : 2;
        fend = 1 + lead + 10 + ((c == 2'b11) ? (turn + 8) : 0);
        cap0 = fend - 8;
        ss_low = 0; n_done = 0; done_at = -1; n_rv = 0; stray = 0;
        got_frame = '0; rd_end = '0; busy_end = 1'b1;

        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);
        start = 1'b1; cmd = c; wdata = d;
        @(posedge clk);
        for (int k = 1; k <= fend + GAP; k++) begin
            @(negedge clk);
            start = poke && (k == 6);
            if (c == 2'b11 && k >= cap0 && k < fend) miso = reply[3'(7 - (k - cap0))];
            else miso = 1'b0;
            if (k >= 1 + lead && k <= lead + 10) got_frame = {got_frame[8:0], mosi};
            else if (mosi) stray++;
            if (!ss_n) ss_low++;
            if (done) begin n_done++; done_at = k; end
            if (rv) n_rv++;
            if (k == fend) rd_end = rdata;
            if (k == fend + GAP) busy_end = busy;
        end
        if (c == 2'b11) exp_rdata = reply;

        if (c == 2'b11) check_eq("frame_cmd", 32'(got_frame[9:8]), 32'(c));
        else            check_eq("frame", 32'(got_frame), 32'({c, d}));
        check_eq("mosi_idle_zero", 32'(stray), 32'd0);
        check_eq("ss_low_cycles", 32'(ss_low), 32'(fend - 1));
        check_eq("done_count", 32'(n_done), 32'd1);
        check_eq("done_cycle", 32'(done_at), 32'(fend));
        check_eq("rdata_valid_count", 32'(n_rv), (c == 2'b11) ? 32'd1 : 32'd0);
        check_eq("rdata", 32'(rd_end), 32'(exp_rdata));
        check_eq("busy_after_gap", 32'(busy_end), 32'd0);
    endtask

    // Apply a command through the slave model and update model state.
    task automatic slave_txn(input logic [1:0] c, input logic [7:0] d, input bit poke);
        run_txn(c, d, mem[raddr], poke);
        case (c)
            2'b00: waddr = d;
            2'b01: mem[waddr] = d;
            2'b10: raddr = d;
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 8'h00;
    endtask

    logic [1:0] rc;
    logic [7:0] rd;
    int         n_done, d_at [3], ss_hi, cy_done;

    initial begin
        rst_n = 1'b0; start = 1'b0; cmd = 2'b00; wdata = 8'h00; miso = 1'b0; sel = 1'b0;
        exp_rdata = 8'h00; waddr = 8'h00; raddr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        #12;
        check_eq("rst_ss_n", 32'(ss_n), 32'd1);
        check_eq("rst_mosi", 32'(mosi), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rdata_valid", 32'(rv), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full loop through the RAM model.
        slave_txn(2'b00, 8'h3A, 1'b0);
        slave_txn(2'b01, 8'hC5, 1'b0);
        slave_txn(2'b10, 8'h3A, 1'b0);
        slave_txn(2'b11, 8'h00, 1'b0);
        check_eq("loop_readback", 32'(exp_rdata), 32'h0C5);

        // Random command mix over a small address space so reads hit writes.
        for (int n = 0; n < 24; n++) begin
            rc = 2'($urandom_range(0, 3));
            rd = (rc[0] == 1'b0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            slave_txn(rc, rd, 1'b0);
        end

        // start pulsed mid-SHIFT is ignored.
        slave_txn(2'b01, 8'h69, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check_eq("poke_no_second_frame", 32'({ss_n, busy}), 32'b10);
        end

        // start held for three writes: 12-cycle period, one-cycle SS_n gap.
        @(negedge clk);
        start = 1'b1; cmd = 2'b00; wdata = 8'h5C;
        n_done = 0; ss_hi = 0; cy_done = 0;
        @(posedge clk);
        for (int cy = 1; cy <= 50; cy++) begin
            @(negedge clk);
            if (cy <= 35 && ss_n) ss_hi++;
            if (done) begin
                if (n_done < 3) d_at[n_done] = cy;
                n_done++;
            end
            if (n_done >= 3 || cy >= 45) start = 1'b0;
        end
        check_eq("b2b_done_count", 32'(n_done), 32'd3);
        check_eq("b2b_first_done", 32'(d_at[0]), 32'd12);
        check_eq("b2b_spacing_1", 32'(d_at[1] - d_at[0]), 32'd12);
        check_eq("b2b_spacing_2", 32'(d_at[2] - d_at[1]), 32'd12);
        check_eq("b2b_ss_high", 32'(ss_hi), 32'd2);
        waddr = 8'h5C;

        // Reset at the 5th SHIFT bit.
        @(negedge clk);
        start = 1'b1; cmd = 2'b00; wdata = 8'h96;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ss_n", 32'(ss_n), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_mosi", 32'(mosi), 32'd0);
        cy_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) cy_done++;
        end
        check_eq("midrst_no_done", 32'(cy_done), 32'd0);
        rst_n = 1'b1;
        exp_rdata = 8'h00;
        check_eq("midrst_rdata_cleared", 32'(rdata), 32'd0);
        slave_txn(2'b00, 8'h3A, 1'b0);

        // Parameter sweep instance: LEAD=3, TURN=1.
        do_reset();
        sel = 1'b1;
        run_txn(2'b00, 8'h3A, 8'h00, 1'b0);
        run_txn(2'b11, 8'h00, 8'hA5, 1'b0);
        check_eq("sweep_rdata", 32'(exp_rdata), 32'h0A5);
        run_txn(2'b01, 8'h4B, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
